// File: rtl/cmp_pipe_if.sv
// Request/result handshake bundle for cmp_pipe: producer side (in_*) and consumer side (out_*).
interface cmp_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_imm;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_imm, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_imm, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_illegal, out_tag
  );
endinterface

// File: rtl/cmp_pipe.sv
// Compare unit feeding a 2-entry in-order result FIFO with registered in_ready.
// Optional feature macro CMP_PIPE_STATS_EN adds saturating consumed/true counters.
module cmp_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      flush,
  cmp_pipe_if.slave bus
`ifdef CMP_PIPE_STATS_EN
  ,
  output logic [31:0] stat_total,
  output logic [31:0] stat_true
`endif
);

  localparam logic [3:0] OP_EQ    = 4'd0;
  localparam logic [3:0] OP_SLT   = 4'd1;
  localparam logic [3:0] OP_SLTI  = 4'd2;
  localparam logic [3:0] OP_SLTIU = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_NE    = 4'd5;
  localparam logic [3:0] OP_LEZ   = 4'd6;
  localparam logic [3:0] OP_GTZ   = 4'd7;
  localparam logic [3:0] OP_LTZ   = 4'd8;
  localparam logic [3:0] OP_GEZ   = 4'd9;

  // Returns {illegal, result}; zero tests use the sign bit plus an all-zero check.
  function automatic logic [1:0] cmp_eval(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] imm);
    logic a_neg;
    logic a_zero;
    a_neg  = a[WIDTH-1];
    a_zero = (a == {WIDTH{1'b0}});
    case (op)
      OP_EQ:    cmp_eval = {1'b0, (a == b)};
      OP_NE:    cmp_eval = {1'b0, (a != b)};
      OP_SLT:   cmp_eval = {1'b0, ($signed(a) < $signed(b))};
      OP_SLTU:  cmp_eval = {1'b0, (a < b)};
      OP_SLTI:  cmp_eval = {1'b0, ($signed(a) < $signed(imm))};
      OP_SLTIU: cmp_eval = {1'b0, (a < imm)};
      OP_LEZ:   cmp_eval = {1'b0, (a_neg | a_zero)};
      OP_GTZ:   cmp_eval = {1'b0, (~a_neg & ~a_zero)};
      OP_LTZ:   cmp_eval = {1'b0, a_neg};
      OP_GEZ:   cmp_eval = {1'b0, ~a_neg};
      default:  cmp_eval = 2'b10;
    endcase
  endfunction

  logic [1:0]            count_r;
  logic                  wr_ptr_r;
  logic                  rd_ptr_r;
  logic                  in_ready_r;
  logic [1:0]            res_r;
  logic [1:0]            ill_r;
  logic [1:0][TAG_W-1:0] tag_r;

  logic       push_s;
  logic       pop_s;
  logic       out_valid_s;
  logic [1:0] eval_s;
  logic [1:0] count_nxt_s;

  // A flush cancels any handshake on the same edge.
  assign out_valid_s = (count_r != 2'd0);
  assign push_s      = bus.in_valid & in_ready_r & ~flush;
  assign pop_s       = out_valid_s & bus.out_ready & ~flush;
  assign eval_s      = cmp_eval(bus.in_op, bus.in_a, bus.in_b, bus.in_imm);

  // Next occupancy from the push/pop/flush combination.
  always_comb begin
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = 2'd0;
    end else if (push_s && !pop_s) begin
      count_nxt_s = count_r + 2'd1;
    end else if (!push_s && pop_s) begin
      count_nxt_s = count_r - 2'd1;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Occupancy, pointers and the registered ready flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r    <= 2'd0;
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      in_ready_r <= 1'b0;
    end else begin
      count_r    <= count_nxt_s;
      in_ready_r <= (count_nxt_s < 2'd2);
      if (flush) begin
        wr_ptr_r <= 1'b0;
        rd_ptr_r <= 1'b0;
      end else begin
        if (push_s) wr_ptr_r <= ~wr_ptr_r;
        if (pop_s)  rd_ptr_r <= ~rd_ptr_r;
      end
    end
  end

  // Result storage; only the single result bit is kept and zero-extended on output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_r <= 2'b00;
      ill_r <= 2'b00;
      tag_r <= {(2*TAG_W){1'b0}};
    end else if (push_s) begin
      res_r[wr_ptr_r] <= eval_s[0];
      ill_r[wr_ptr_r] <= eval_s[1];
      tag_r[wr_ptr_r] <= bus.in_tag;
    end
  end

  // Present the head entry, forcing zeros while empty.
  always_comb begin
    bus.out_res     = {WIDTH{1'b0}};
    bus.out_illegal = 1'b0;
    bus.out_tag     = {TAG_W{1'b0}};
    if (out_valid_s) begin
      bus.out_res     = {{(WIDTH-1){1'b0}}, res_r[rd_ptr_r]};
      bus.out_illegal = ill_r[rd_ptr_r];
      bus.out_tag     = tag_r[rd_ptr_r];
    end else begin
      bus.out_res     = {WIDTH{1'b0}};
      bus.out_illegal = 1'b0;
      bus.out_tag     = {TAG_W{1'b0}};
    end
  end

  assign bus.out_valid = out_valid_s;
  assign bus.in_ready  = in_ready_r;

`ifdef CMP_PIPE_STATS_EN
  logic [31:0] stat_total_r;
  logic [31:0] stat_true_r;

  // Saturating counters of consumed results; flush does not touch them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_total_r <= 32'd0;
      stat_true_r  <= 32'd0;
    end else if (pop_s) begin
      if (stat_total_r != 32'hFFFF_FFFF) stat_total_r <= stat_total_r + 32'd1;
      if (res_r[rd_ptr_r] && (stat_true_r != 32'hFFFF_FFFF)) stat_true_r <= stat_true_r + 32'd1;
    end
  end

  assign stat_total = stat_total_r;
  assign stat_true  = stat_true_r;
`endif

endmodule

// File: tb/tb_cmp_pipe.sv
// Directed self-checking bench for cmp_pipe (32-bit instance plus an 8-bit instance).
module tb_cmp_pipe;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cmp_pipe_if #(.WIDTH(32), .TAG_W(5)) bus ();
  cmp_pipe_if #(.WIDTH(8),  .TAG_W(5)) bus8 ();

`ifdef CMP_PIPE_STATS_EN
  logic [31:0] stat_total, stat_true, stat_total8, stat_true8;
`endif

  cmp_pipe #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus.slave)
`ifdef CMP_PIPE_STATS_EN
    , .stat_total(stat_total), .stat_true(stat_true)
`endif
  );

  cmp_pipe #(.WIDTH(8), .TAG_W(5)) dut8 (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus8.slave)
`ifdef CMP_PIPE_STATS_EN
    , .stat_total(stat_total8), .stat_true(stat_true8)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [4:0] tag);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_imm   = imm;
    bus.in_tag   = tag;
  endtask

  task automatic test_reset();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    bus.out_ready  = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.in_op     = 4'd0;
    bus8.in_a      = 8'd0;
    bus8.in_b      = 8'd0;
    bus8.in_imm    = 8'd0;
    bus8.in_tag    = 5'd0;
    bus8.out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready",    {63'd0, bus.in_ready}, 64'd0);
    chk("rst_out_valid",   {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_res",     {32'd0, bus.out_res}, 64'd0);
    chk("rst_out_illegal", {63'd0, bus.out_illegal}, 64'd0);
    chk("rst_out_tag",     {59'd0, bus.out_tag}, 64'd0);
    reset = 1'b1;
    #1;
    chk("rst_release_pre", {63'd0, bus.in_ready}, 64'd0);
    step();
    chk("rst_release_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_release_valid", {63'd0, bus.out_valid}, 64'd0);
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    drive(1'b1, 4'd1, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd3);
    step();
    chk("basic_slt_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("basic_slt_res",   {32'd0, bus.out_res}, 64'd1);
    chk("basic_slt_tag",   {59'd0, bus.out_tag}, 64'd3);
    drive(1'b1, 4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd4);
    step();
    chk("basic_sltu_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("basic_sltu_res",   {32'd0, bus.out_res}, 64'd0);
    chk("basic_sltu_tag",   {59'd0, bus.out_tag}, 64'd4);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    step();
    chk("basic_drain_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("basic_drain_tag",   {59'd0, bus.out_tag}, 64'd0);
  endtask

  task automatic test_ops();
    logic [3:0]  ops [19] = '{4'd0, 4'd5, 4'd5, 4'd1, 4'd4, 4'd2, 4'd3, 4'd3, 4'd6, 4'd7,
                              4'd8, 4'd9, 4'd7, 4'd8, 4'd6, 4'd9, 4'd12, 4'd15, 4'd0};
    logic [31:0] va  [19] = '{32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFE,
                              32'hFFFF_FFFE, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1,
                              32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd5, 32'd5, 32'd5};
    logic [31:0] vb  [19] = '{32'd5, 32'd5, 32'd6, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                              32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                              32'd0, 32'd0, 32'd0, 32'd5, 32'd5, 32'd6};
    logic [31:0] vi  [19] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1,
                              32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                              32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    logic        er  [19] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                              1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        ei  [19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 19; i++) begin
      bus.out_ready = 1'b0;
      drive(1'b1, ops[i], va[i], vb[i], vi[i], 5'(i));
      step();
      drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_res !== {31'd0, er[i]} ||
          bus.out_illegal !== ei[i] || bus.out_tag !== 5'(i)) begin
        errors++;
        $display("FAIL op_vec%0d op=%0d: got valid=%b res=%0h ill=%b tag=%0d expected valid=1 res=%0h ill=%b tag=%0d",
                 i, ops[i], bus.out_valid, bus.out_res, bus.out_illegal, bus.out_tag, er[i], ei[i], i);
      end
      bus.out_ready = 1'b1;
      step();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_res !== 32'd0 || bus.out_illegal !== 1'b0) begin
        errors++;
        $display("FAIL op_drain%0d: got valid=%b res=%0h ill=%b expected 0 0 0",
                 i, bus.out_valid, bus.out_res, bus.out_illegal);
      end
    end
  endtask

  task automatic test_width8();
    logic [3:0] ops [3] = '{4'd8, 4'd1, 4'd4};
    logic       er  [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      bus8.out_ready = 1'b0;
      bus8.in_valid  = 1'b1;
      bus8.in_op     = ops[i];
      bus8.in_a      = 8'h80;
      bus8.in_b      = 8'h7F;
      bus8.in_imm    = 8'h00;
      bus8.in_tag    = 5'(i + 20);
      step();
      bus8.in_valid = 1'b0;
      checks++;
      if (bus8.out_valid !== 1'b1 || bus8.out_res !== {7'd0, er[i]} || bus8.out_tag !== 5'(i + 20)) begin
        errors++;
        $display("FAIL w8_vec%0d: got valid=%b res=%0h tag=%0d expected valid=1 res=%0h tag=%0d",
                 i, bus8.out_valid, bus8.out_res, bus8.out_tag, er[i], i + 20);
      end
      bus8.out_ready = 1'b1;
      step();
    end
    chk("w8_drained", {63'd0, bus8.out_valid}, 64'd0);
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    step();
    chk("bp_ready_after1", {63'd0, bus.in_ready}, 64'd1);
    chk("bp_tag_head0",    {59'd0, bus.out_tag}, 64'd0);
    drive(1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 5'd1);
    step();
    chk("bp_ready_after2", {63'd0, bus.in_ready}, 64'd0);
    drive(1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 5'd2);
    step();
    chk("bp_ready_full",  {63'd0, bus.in_ready}, 64'd0);
    chk("bp_hold_tag",    {59'd0, bus.out_tag}, 64'd0);
    chk("bp_hold_res",    {32'd0, bus.out_res}, 64'd1);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    bus.out_ready = 1'b1;
    step();
    chk("bp_order_tag1", {59'd0, bus.out_tag}, 64'd1);
    chk("bp_ready_back", {63'd0, bus.in_ready}, 64'd1);
    step();
    chk("bp_third_lost", {63'd0, bus.out_valid}, 64'd0);
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    drive(1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 5'd4);
    step();
    drive(1'b1, 4'd5, 32'd0, 32'd0, 32'd0, 5'd5);
    step();
    chk("b2b_full", {63'd0, bus.in_ready}, 64'd0);
    // Full: offered request is refused while the head leaves.
    drive(1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 5'd6);
    bus.out_ready = 1'b1;
    step();
    chk("b2b_head5",   {59'd0, bus.out_tag}, 64'd5);
    chk("b2b_res5",    {32'd0, bus.out_res}, 64'd0);
    chk("b2b_ready1",  {63'd0, bus.in_ready}, 64'd1);
    // Push and pop together at occupancy 1.
    step();
    chk("b2b_pp_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("b2b_pp_head6", {59'd0, bus.out_tag}, 64'd6);
    chk("b2b_pp_ready", {63'd0, bus.in_ready}, 64'd1);
    drive(1'b1, 4'd0, 32'd0, 32'd1, 32'd0, 5'd7);
    bus.out_ready = 1'b0;
    step();
    chk("b2b_refill_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("b2b_refill_head",  {59'd0, bus.out_tag}, 64'd6);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    bus.out_ready = 1'b1;
    step();
    chk("b2b_head7", {59'd0, bus.out_tag}, 64'd7);
    chk("b2b_res7",  {32'd0, bus.out_res}, 64'd0);
    step();
    chk("b2b_empty", {63'd0, bus.out_valid}, 64'd0);
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 5'd8);
    step();
    drive(1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 5'd9);
    step();
    drive(1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 5'd10);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    chk("flush_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("flush_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("flush_tag",   {59'd0, bus.out_tag}, 64'd0);
    step();
    chk("flush_still_empty", {63'd0, bus.out_valid}, 64'd0);
    // Flush at occupancy 1 with an acceptable request pending.
    bus.out_ready = 1'b0;
    drive(1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 5'd11);
    step();
    drive(1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 5'd12);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    chk("flush1_valid", {63'd0, bus.out_valid}, 64'd0);
    step();
    chk("flush1_push_lost", {63'd0, bus.out_valid}, 64'd0);
    bus.out_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    drive(1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 5'd13);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    chk("arst_pre_valid", {63'd0, bus.out_valid}, 64'd1);
    reset = 1'b0;
    #1;
    chk("arst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("arst_tag",   {59'd0, bus.out_tag}, 64'd0);
    chk("arst_res",   {32'd0, bus.out_res}, 64'd0);
    chk("arst_ready", {63'd0, bus.in_ready}, 64'd0);
    step();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    step();
    chk("arst_release_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("arst_release_valid", {63'd0, bus.out_valid}, 64'd0);
  endtask

`ifdef CMP_PIPE_STATS_EN
  task automatic test_stats();
    logic [31:0] av [5] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    logic [31:0] bv [5] = '{32'd1, 32'd9, 32'd3, 32'd0, 32'd5};
    chk("stat_rst_total", {32'd0, stat_total}, 64'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'd0, av[i], bv[i], 32'd0, 5'(i));
      step();
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    step();
    chk("stat_total5", {32'd0, stat_total}, 64'd5);
    chk("stat_true3",  {32'd0, stat_true}, 64'd3);
    dut.stat_total_r = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0);
      step();
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    step();
    chk("stat_saturate", {32'd0, stat_total}, 64'hFFFF_FFFF);
    chk("stat_true6",    {32'd0, stat_true}, 64'd6);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ops();
    test_width8();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
`ifdef CMP_PIPE_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
